// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage divider.
//   DIV_W / DIV_CNT_W : default operand width and iteration counter width.
//   DIVBYZERO_QUOT    : quotient returned for a zero divisor (all ones).
//   div_state_t       : divider FSM state encoding.
package cpu_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_CNT_W = 6;

  localparam logic [DIV_W-1:0] DIVBYZERO_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation of two values at once.
// Used ahead of the divider to turn signed operands into magnitudes, and after
// it to apply the result signs to quotient and remainder.
// Ports:
//   x, x_neg : first value and its negate request
//   y, y_neg : second value and its negate request
//   x_fix    : x_neg ? -x : x
//   y_fix    : y_neg ? -y : y
module div_sign_fix
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] x,
  input  logic             x_neg,
  input  logic [WIDTH-1:0] y,
  input  logic             y_neg,
  output logic [WIDTH-1:0] x_fix,
  output logic [WIDTH-1:0] y_fix
);

  // -(-2^(W-1)) wraps to itself, which is exactly the unsigned magnitude we need.
  assign x_fix = x_neg ? (~x + WIDTH'(1)) : x;
  assign y_fix = y_neg ? (~y + WIDTH'(1)) : y;

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EX stage.
// One quotient bit per cycle, MSB first; WIDTH+1 cycles from start to valid,
// one cycle for a zero divisor.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   start      : launch a divide (honoured only in IDLE)
//   signed_div : 1 = DIV (two's complement), 0 = DIVU
//   a, b       : dividend / divisor, captured with start
//   annul      : flush; abandons the operation in flight, suppresses valid
//   stall      : stall request to the hazard unit
//   valid      : one-cycle result pulse
//   quot, rem  : quotient (LO) and remainder (HI); held until the next result
// Build option:
//   DIV_EARLY_OUT_EN : finish in one cycle when |a| < |b|; results unchanged.
module div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W,     // even, >= 4
  parameter int unsigned CNT_W = DIV_CNT_W  // 2**CNT_W > WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic             stall,
  output logic             valid,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  div_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;   // partial remainder
  logic [WIDTH-1:0] work_q, work_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;   // divisor magnitude
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quot_q, rem_q;    // last delivered result

  // Operand magnitudes
  logic             a_neg, b_neg, b_zero, early;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg  = signed_div & a[WIDTH-1];
  assign b_neg  = signed_div & b[WIDTH-1];
  assign b_zero = (b == '0);

  div_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_in (
    .x     (a),
    .x_neg (a_neg),
    .y     (b),
    .y_neg (b_neg),
    .x_fix (a_mag),
    .y_fix (b_mag)
  );

`ifdef DIV_EARLY_OUT_EN
  assign early = (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  // One restoring step. prem_q < 2^WIDTH, so WIDTH+2 bits hold the shift and the
  // borrow of the trial subtraction.
  logic [WIDTH+1:0] shifted, trial;
  logic             restore;

  assign shifted = {prem_q, work_q[WIDTH-1]};
  assign trial   = shifted - {2'b00, dvsr_q};
  assign restore = trial[WIDTH+1];

  // Signed results
  logic [WIDTH-1:0] quot_res, rem_res;

  div_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_out (
    .x     (work_q),
    .x_neg (negq_q),
    .y     (prem_q[WIDTH-1:0]),
    .y_neg (negr_q),
    .x_fix (quot_res),
    .y_fix (rem_res)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start && !annul) begin
          state_d = (b_zero || early) ? DONE : CALC;
        end
      end
      CALC: begin
        if (annul) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    stall = ((state_q == IDLE) && start && !annul) || (state_q == CALC);
    valid = (state_q == DONE) && !annul;
    // Present the fresh result during DONE; otherwise show the held one.
    quot  = valid ? quot_res : quot_q;
    rem   = valid ? rem_res  : rem_q;
  end

  // Datapath next state
  always_comb begin
    cnt_d  = cnt_q;
    prem_d = prem_q;
    work_d = work_q;
    dvsr_d = dvsr_q;
    negq_d = negq_q;
    negr_d = negr_q;
    if ((state_q == IDLE) && start && !annul) begin
      dvsr_d = b_mag;
      negq_d = a_neg ^ b_neg;
      negr_d = a_neg;
      cnt_d  = CNT_W'(WIDTH - 1);
      if (b_zero) begin
        // Bypass CALC; unsigned quotient of all ones, remainder re-signed to a.
        work_d = DIVBYZERO_QUOT[WIDTH-1:0] | '1;
        prem_d = {1'b0, a_mag};
        negq_d = 1'b0;
      end else if (early) begin
        work_d = '0;
        prem_d = {1'b0, a_mag};
        negq_d = 1'b0;
      end else begin
        work_d = a_mag;
        prem_d = '0;
      end
    end else if ((state_q == CALC) && !annul) begin
      prem_d = restore ? shifted[WIDTH:0] : trial[WIDTH:0];
      work_d = {work_q[WIDTH-2:0], ~restore};
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      prem_q <= '0;
      work_q <= '0;
      dvsr_q <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      prem_q <= prem_d;
      work_q <= work_d;
      dvsr_q <= dvsr_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end

  // Result hold registers; an annulled DONE leaves them untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quot_q <= '0;
      rem_q  <= '0;
    end else if ((state_q == DONE) && !annul) begin
      quot_q <= quot_res;
      rem_q  <= rem_res;
    end
  end

endmodule
